// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM -> data RAM load/store -> MEM/WB register.
// Latency: 1 cycle for pass-through ops, 1+WAIT_STATES cycles for loads/stores.
// Backpressure: stall is raised combinationally while a memory access is still in flight.
module mem_stage #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [1:0]  ctlwb_in,
   input  logic [1:0]  ctlm_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] rdata2,
   input  logic [4:0]  muxout,
   output logic        stall,
   output logic        valid_out,
   output logic [1:0]  ctlwb_out,
   output logic [31:0] read_data_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  muxout_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
   localparam bit HAS_WAIT = (WAIT_STATES > 0);
   localparam logic [CW-1:0] WS_LAST = CW'(WAIT_STATES);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   mem [DEPTH];

   logic          mem_read;
   logic          mem_write;
   logic          mem_op;
   logic          complete;
   logic [AW-1:0] idx;

   assign mem_read  = ctlm_in[1];
   assign mem_write = ctlm_in[0];
   assign mem_op    = valid_in & (mem_read | mem_write);
   // Byte offset ignored and upper bits dropped: the address wraps modulo DEPTH.
   assign idx       = alu_result[AW+1:2];

   // Completion cycle: the MEM/WB register loads at the coming edge.
   always_comb begin
      complete = 1'b0;
      if (state == IDLE)
         complete = !mem_op || !HAS_WAIT;
      else
         complete = (cnt == WS_LAST);
   end

   // Stall while the access has not reached its completion cycle; reset drops it at once.
   always_comb begin
      stall = 1'b0;
      if (rst_n) begin
         if (state == IDLE)
            stall = mem_op && HAS_WAIT;
         else
            stall = (cnt < WS_LAST);
      end
   end

   // Data RAM write port; not reset so stored contents survive a reset, and a
   // store that is still waiting when reset arrives is never committed.
   always_ff @(posedge clk) begin
      if (rst_n && complete && valid_in && mem_write)
         mem[idx] <= rdata2;
   end

   // Wait-state sequencer and MEM/WB pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         valid_out      <= 1'b0;
         ctlwb_out      <= 2'b00;
         read_data_out  <= '0;
         alu_result_out <= '0;
         muxout_out     <= '0;
      end else begin
         if (complete) begin
            state          <= IDLE;
            cnt            <= '0;
            valid_out      <= valid_in;
            // A bubble must never write the register file.
            ctlwb_out      <= valid_in ? ctlwb_in : 2'b00;
            // Read sees the pre-write word when MemRead and MemWrite are both set.
            read_data_out  <= (valid_in && mem_read) ? mem[idx] : 32'd0;
            alu_result_out <= alu_result;
            muxout_out     <= muxout;
         end else begin
            // Access still in flight: push a bubble into MEM/WB.
            valid_out <= 1'b0;
            ctlwb_out <= 2'b00;
            if (state == IDLE) begin
               state <= WAIT;
               cnt   <= CW'(1);
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits directly downstream of the execute stage and consumes its EX/MEM outputs: WB/M control, ALU result, forwarded rs2 data and destination register. It performs data-memory loads and stores against an internal word-addressed RAM with configurable wait states, stalling upstream while an access is in flight. It presents the MEM/WB pipeline register to write-back.

## Interface
- DEPTH, 256: data-memory size in 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles per memory access; 0 means single-cycle access.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  EX/MEM slot holds a real instruction.
- ctlwb_in  input  2  [1]=RegWrite, [0]=MemtoReg; carried to the WB stage unchanged.
- ctlm_in  input  2  [1]=MemRead, [0]=MemWrite.
- alu_result  input  32  effective address, or ALU result for non-memory ops.
- rdata2  input  32  store data.
- muxout  input  5  destination register.
- stall  output  1  combinational; upstream must hold every input while high.
- valid_out  output  1  MEM/WB slot valid.
- ctlwb_out  output  2  registered ctlwb_in.
- read_data_out  output  32  registered load data; 0 for non-loads.
- alu_result_out  output  32  registered alu_result.
- muxout_out  output  5  registered muxout.

## Operation
- Word index: alu_result[log2(DEPTH)+1:2]. Bits [1:0] are ignored, so no alignment fault is raised. Upper bits are discarded, so addresses wrap modulo DEPTH.
- Memory op: valid_in=1 and (MemRead or MemWrite). Any other slot is a pass-through op.
- FSM states:
  - IDLE:
    - Pass-through op: MEM/WB loads at the next edge and stall=0.
    - Memory op with WAIT_STATES=0: the access completes at the next edge.
    - Memory op with WAIT_STATES>0: stall=1 in the same cycle; at the edge, go to WAIT with cnt=1 and keep MEM/WB valid_out=0 (bubble).
  - WAIT: stall = (cnt < WAIT_STATES).
    - While cnt < WAIT_STATES: cnt increments each edge and bubbles continue.
    - When cnt == WAIT_STATES: this is the completion cycle. stall=0; the store is written and MEM/WB loads at the edge. Return to IDLE with cnt=0.
- Completion edge actions:
  - MemWrite: mem[index] <= rdata2.
  - MemRead: read_data_out <= mem[index], which is the pre-write value if MemWrite is also set.
  - Always: valid_out <= 1; ctlwb_out, alu_result_out and muxout_out are loaded.
- MemRead and MemWrite both set: the store is performed, and the load returns the old contents.
- valid_in=0: valid_out <= 0 and ctlwb_out <= 2'b00, so a bubble never writes the register file. Other fields are don't-care but are still loaded.
- Memory contents are not cleared by reset. The bench initialises them by issuing stores.

## Timing
- Reset (asynchronous, immediate):
  - All outputs are 0: valid_out, ctlwb_out, read_data_out, alu_result_out and muxout_out.
  - FSM goes to IDLE with cnt=0.
  - stall falls combinationally.
- Reset during WAIT aborts the access, and a pending store is not committed.
- Latency from the edge that captures the EX/MEM inputs to MEM/WB visibility:
  - 1 cycle for a pass-through op.
  - 1+WAIT_STATES cycles for a memory op.
- stall is high for exactly WAIT_STATES consecutive cycles per memory op, starting the cycle the op is presented.
- Back-to-back memory ops: the second op may be presented in the cycle stall drops. Its own stall window starts immediately, with no idle gap.
- Inputs may change during a stall; the behaviour is then undefined, and the bench checks that they are held.

## Test plan
- Reset: assert rst_n=0 mid-cycle during WAIT with WAIT_STATES=2 and a store of 32'hDEAD to address 8 pending. Required: all outputs go to 0 immediately and stall=0. A later load from address 8 returns the prior contents.
- Pass-through: R-type with alu_result=30, muxout=10, ctlwb=2'b10, ctlm=2'b00. Required: after one edge, alu_result_out=30, muxout_out=10, valid_out=1, read_data_out=0, stall never high.
- Store then load, WAIT_STATES=1:
  - Store rdata2=32'd1234 to alu_result=120. Required: stall high for 1 cycle, one bubble in MEM/WB.
  - Then load from 120 with ctlwb=2'b11, muxout=5. Required: read_data_out=1234 and muxout_out=5, two cycles after presentation.
- Wrap and misalign, DEPTH=256: store 32'hA5A5 at address 1024+4+3. Required: a load from address 4 returns 32'hA5A5.
- Read+write in one op: mem[3]=7, then an op with both bits set, rdata2=9, address 12. Required: read_data_out=7, and a subsequent load from address 12 returns 9.
- WAIT_STATES=0 sweep: 16 consecutive alternating store/load ops. Required: stall never high, one result per cycle, all load data correct.
